// File: rtl/sad_accumulator.sv
// SAD accumulator for the VBSME datapath: per-candidate sum of absolute differences with a running minimum tracker.
// Optional early termination of hopeless candidates is enabled by defining SAD_EARLY_TERM_EN.
module sad_accumulator #(
    parameter int BLOCK_WORDS = 4,
    parameter int IDX_W = 10,
    localparam int SAD_W = 10 + $clog2(BLOCK_WORDS)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             InValid,
    output logic             InReady,
    input  logic [31:0]      FrameWord,
    input  logic [31:0]      WindowWord,
    input  logic [IDX_W-1:0] InIdx,
    input  logic             LastCand,
    output logic             SadValid,
    output logic [SAD_W-1:0] SadOut,
    output logic [IDX_W-1:0] SadIdx,
    output logic [SAD_W-1:0] MinSad,
    output logic [IDX_W-1:0] MinIdx,
    output logic             Done,
    output logic             Pruned
);

    localparam int CNT_W = $clog2(BLOCK_WORDS);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, FINISH, DONE} stateT;

    stateT            stateReg, stateNext;
    logic [CNT_W-1:0] cntReg, cntNext;
    logic [SAD_W-1:0] accReg, accNext;
    logic [IDX_W-1:0] idxReg, idxNext;
    logic             lastReg, lastNext;
    logic             sadValidReg, sadValidNext;
    logic [SAD_W-1:0] sadOutReg, sadOutNext;
    logic [IDX_W-1:0] sadIdxReg, sadIdxNext;
    logic [SAD_W-1:0] minSadReg, minSadNext;
    logic [IDX_W-1:0] minIdxReg, minIdxNext;
    logic             doneReg, doneNext;

    logic [7:0]       absDiff [4];
    logic [9:0]       wordSad;
    logic [SAD_W-1:0] dExt;
    logic [SAD_W-1:0] sumVal;
    logic             transfer, firstWord, lastWord, blockEnd, pruneActive;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : gByte
            logic [7:0] fPix, wPix;
            assign fPix = FrameWord[8*gi +: 8];
            assign wPix = WindowWord[8*gi +: 8];
            assign absDiff[gi] = (fPix >= wPix) ? fPix - wPix : wPix - fPix;
        end
    endgenerate

    assign wordSad   = 10'(absDiff[0]) + 10'(absDiff[1]) + 10'(absDiff[2]) + 10'(absDiff[3]);
    assign dExt      = SAD_W'(wordSad);
    assign InReady   = (stateReg == ACCUM);
    assign transfer  = InValid && InReady;
    assign firstWord = (cntReg == '0);
    assign lastWord  = (cntReg == LAST_WORD);
    assign blockEnd  = transfer && lastWord && !Start;
    // Word 0 loads rather than adds; a pruned candidate keeps its frozen value.
    assign sumVal    = firstWord ? dExt : (pruneActive ? accReg : accReg + dExt);

    // Min tracker: Start wins over the compare of a pulse already on the outputs.
    always_comb begin
        minSadNext = minSadReg;
        minIdxNext = minIdxReg;
        if (Start) begin
            minSadNext = '1;
            minIdxNext = '0;
        end else if (sadValidReg && !Pruned && (sadOutReg < minSadReg)) begin
            minSadNext = sadOutReg;
            minIdxNext = sadIdxReg;
        end
    end

    always_comb begin
        stateNext    = stateReg;
        cntNext      = cntReg;
        accNext      = accReg;
        idxNext      = idxReg;
        lastNext     = lastReg;
        sadValidNext = 1'b0;
        sadOutNext   = sadOutReg;
        sadIdxNext   = sadIdxReg;
        doneNext     = 1'b0;
        if (Start) begin
            stateNext = ACCUM;
            cntNext   = '0;
            accNext   = '0;
        end else begin
            case (stateReg)
                ACCUM: begin
                    if (transfer) begin
                        accNext = sumVal;
                        if (firstWord) begin
                            idxNext  = InIdx;
                            lastNext = LastCand;
                        end
                        if (blockEnd) begin
                            cntNext      = '0;
                            sadValidNext = 1'b1;
                            sadOutNext   = sumVal;
                            sadIdxNext   = idxReg;
                            if (lastReg) stateNext = FINISH;
                        end else begin
                            cntNext = cntReg + CNT_W'(1);
                        end
                    end
                end
                FINISH: begin
                    stateNext = DONE;
                    doneNext  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            stateReg    <= IDLE;
            cntReg      <= '0;
            accReg      <= '0;
            idxReg      <= '0;
            lastReg     <= 1'b0;
            sadValidReg <= 1'b0;
            sadOutReg   <= '0;
            sadIdxReg   <= '0;
            minSadReg   <= '1;
            minIdxReg   <= '0;
            doneReg     <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            cntReg      <= cntNext;
            accReg      <= accNext;
            idxReg      <= idxNext;
            lastReg     <= lastNext;
            sadValidReg <= sadValidNext;
            sadOutReg   <= sadOutNext;
            sadIdxReg   <= sadIdxNext;
            minSadReg   <= minSadNext;
            minIdxReg   <= minIdxNext;
            doneReg     <= doneNext;
        end
    end

`ifdef SAD_EARLY_TERM_EN
    logic pruneFlagReg, prunedReg;

    // A stale flag from the previous candidate is ignored on word 0.
    assign pruneActive = pruneFlagReg && !firstWord;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pruneFlagReg <= 1'b0;
            prunedReg    <= 1'b0;
        end else begin
            prunedReg <= blockEnd && pruneActive;
            if (Start) begin
                pruneFlagReg <= 1'b0;
            end else if (transfer && !lastWord) begin
                pruneFlagReg <= pruneActive || (sumVal >= minSadNext);
            end
        end
    end

    assign Pruned = prunedReg;
`else
    assign pruneActive = 1'b0;
    assign Pruned      = 1'b0;
`endif

    assign SadValid = sadValidReg;
    assign SadOut   = sadOutReg;
    assign SadIdx   = sadIdxReg;
    assign MinSad   = minSadReg;
    assign MinIdx   = minIdxReg;
    assign Done     = doneReg;

endmodule

// File: tb/tb_sad_accumulator.sv
// Scoreboard bench for sad_accumulator: directed candidate blocks with hand-computed SADs and minimum tracking.
module tb_sad_accumulator;

    localparam logic [11:0] ALL_ONES = 12'hFFF;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic        InValid;
    logic        InReady;
    logic [31:0] FrameWord;
    logic [31:0] WindowWord;
    logic [9:0]  InIdx;
    logic        LastCand;
    logic        SadValid;
    logic [11:0] SadOut;
    logic [9:0]  SadIdx;
    logic [11:0] MinSad;
    logic [9:0]  MinIdx;
    logic        Done;
    logic        Pruned;

    sad_accumulator #(.BLOCK_WORDS(4), .IDX_W(10)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .InValid(InValid), .InReady(InReady),
        .FrameWord(FrameWord), .WindowWord(WindowWord), .InIdx(InIdx), .LastCand(LastCand),
        .SadValid(SadValid), .SadOut(SadOut), .SadIdx(SadIdx), .MinSad(MinSad), .MinIdx(MinIdx),
        .Done(Done), .Pruned(Pruned)
    );

    typedef struct {
        logic [11:0] sad;
        logic [9:0]  idx;
        logic        pr;
        logic [11:0] minS;
        logic [9:0]  minI;
    } expT;

    expT sbQ[$];
    expT doneQ[$];
    int  checks = 0;
    int  errors = 0;
    bit  pendMin = 0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Monitor: pops an expectation on every SadValid/Done pulse; MinSad/MinIdx checked one cycle after SadValid.
    initial begin
        expT cur;
        expT d;
        forever begin
            @(negedge Clk);
            if (pendMin) begin
                check("min_sad_after_update", MinSad, cur.minS);
                check("min_idx_after_update", MinIdx, cur.minI);
                pendMin = 0;
            end
            if (SadValid === 1'b1) begin
                if (sbQ.size() == 0) begin
                    failNow("unexpected_sadvalid");
                end else begin
                    cur = sbQ.pop_front();
                    $display("SAD   idx=%0d sad=%0d pruned=%0d (exp idx=%0d sad=%0d pruned=%0d)",
                             SadIdx, SadOut, Pruned, cur.idx, cur.sad, cur.pr);
                    check("sad_out", SadOut, cur.sad);
                    check("sad_idx", SadIdx, cur.idx);
                    check("pruned", Pruned, cur.pr);
                    pendMin = 1;
                end
            end
            if (Done === 1'b1) begin
                if (doneQ.size() == 0) begin
                    failNow("unexpected_done");
                end else begin
                    d = doneQ.pop_front();
                    $display("DONE  min_sad=%0d min_idx=%0d (exp %0d/%0d)", MinSad, MinIdx, d.minS, d.minI);
                    check("done_min_sad", MinSad, d.minS);
                    check("done_min_idx", MinIdx, d.minI);
                end
            end
        end
    end

    task automatic doStart();
        @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    // Non-first words carry a scrambled index/LastCand to prove they are latched on word 0 only.
    task automatic driveWord(input logic [31:0] f, input logic [31:0] w, input logic [9:0] idx,
                             input logic last, input int wordNum);
        int n;
        @(negedge Clk);
        InValid    = 1'b1;
        FrameWord  = f;
        WindowWord = w;
        InIdx      = (wordNum == 0) ? idx : ~idx;
        LastCand   = (wordNum == 0) ? last : ~last;
        n = 0;
        while (InReady !== 1'b1 && n < 20) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 20) failNow("inready_timeout");
    endtask

    task automatic pushDone(input logic [11:0] minS, input logic [9:0] minI);
        expT e;
        e.sad = '0; e.idx = '0; e.pr = 1'b0; e.minS = minS; e.minI = minI;
        doneQ.push_back(e);
    endtask

    task automatic sendBlock(input logic [127:0] f, input logic [127:0] w, input logic [9:0] idx,
                             input logic last, input logic [11:0] expSad, input logic expPr,
                             input logic [11:0] minS, input logic [9:0] minI, input bit gap);
        expT e;
        e.sad = expSad; e.idx = idx; e.pr = expPr; e.minS = minS; e.minI = minI;
        sbQ.push_back(e);
        for (int i = 0; i < 4; i++) begin
            driveWord(f[32*i +: 32], w[32*i +: 32], idx, last, i);
            if (gap && i == 1) begin
                @(negedge Clk);
                InValid   = 1'b0;
                FrameWord = 32'hFFFFFFFF;
            end
        end
        @(negedge Clk);
        InValid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        Reset = 1'b0; Start = 1'b0; InValid = 1'b0; FrameWord = '0; WindowWord = '0;
        InIdx = '0; LastCand = 1'b0;
        repeat (3) @(negedge Clk);
        check("reset_inready", InReady, 0);
        check("reset_sadvalid", SadValid, 0);
        check("reset_done", Done, 0);
        check("reset_pruned", Pruned, 0);
        check("reset_sadout", SadOut, 0);
        check("reset_sadidx", SadIdx, 0);
        check("reset_minsad", MinSad, ALL_ONES);
        check("reset_minidx", MinIdx, 0);
        @(negedge Clk);
        Reset = 1'b1;

        // Identical frame/window words: SAD 0, becomes the minimum.
        pushDone(12'd0, 10'd5);
        doStart();
        sendBlock({4{32'h12345678}}, {4{32'h12345678}}, 10'd5, 1'b1, 12'd0, 1'b0, 12'd0, 10'd5, 1'b0);
        repeat (3) @(negedge Clk);
        check("inready_in_done", InReady, 0);

        // Maximum SAD, no overflow.
        pushDone(12'd4080, 10'd7);
        doStart();
        sendBlock({4{32'hFF00FF00}}, {4{32'h00FF00FF}}, 10'd7, 1'b1, 12'd4080, 1'b0, 12'd4080, 10'd7, 1'b0);
        repeat (3) @(negedge Clk);

        // Multi-candidate search: tie keeps earlier index, smaller SAD replaces, tie at the end keeps idx 3.
        pushDone(12'd12, 10'd3);
        doStart();
        sendBlock({32'h00000010, 32'h00000000, 32'h0000000A, 32'h0A0A0A0A},
                  {32'h0000000B, 32'h00000500, 32'h00000000, 32'h05050505},
                  10'd1, 1'b0, 12'd40, 1'b0, 12'd40, 10'd1, 1'b0);
        sendBlock({4{32'h02020303}}, {4{32'h00000000}}, 10'd2, 1'b0, 12'd40, 1'b0, 12'd40, 10'd1, 1'b1);
        sendBlock({4{32'h00000003}}, {4{32'h00000000}}, 10'd3, 1'b0, 12'd12, 1'b0, 12'd12, 10'd3, 1'b0);
`ifdef SAD_EARLY_TERM_EN
        sendBlock({32'h0000000A, 32'h0000000A, 32'h0000000A, 32'h0A0A0A0A},
                  {32'h00000000, 32'h00000000, 32'h00000000, 32'h05050505},
                  10'd6, 1'b0, 12'd20, 1'b1, 12'd12, 10'd3, 1'b0);
`else
        sendBlock({32'h0000000A, 32'h0000000A, 32'h0000000A, 32'h0A0A0A0A},
                  {32'h00000000, 32'h00000000, 32'h00000000, 32'h05050505},
                  10'd6, 1'b0, 12'd50, 1'b0, 12'd12, 10'd3, 1'b0);
`endif
        sendBlock({4{32'h00010000}}, {4{32'h00000002}}, 10'd10, 1'b1, 12'd12, 1'b0, 12'd12, 10'd3, 1'b0);
        repeat (3) @(negedge Clk);

        // Start after two words: partial block discarded, the word on the Start cycle dropped.
        pushDone(12'd8, 10'd4);
        doStart();
        driveWord(32'h0000000A, 32'h00000000, 10'd9, 1'b0, 0);
        driveWord(32'h0000000A, 32'h00000000, 10'd9, 1'b0, 1);
        @(negedge Clk);
        Start = 1'b1;
        FrameWord = 32'h0000000A;
        @(negedge Clk);
        Start = 1'b0;
        InValid = 1'b0;
        check("restart_minsad", MinSad, ALL_ONES);
        check("restart_minidx", MinIdx, 0);
        sendBlock({4{32'h00000002}}, {4{32'h00000000}}, 10'd4, 1'b1, 12'd8, 1'b0, 12'd8, 10'd4, 1'b0);
        repeat (3) @(negedge Clk);

        // Asynchronous reset in the middle of a block.
        doStart();
        sendBlock({4{32'h00000001}}, {4{32'h00000000}}, 10'd11, 1'b0, 12'd4, 1'b0, 12'd4, 10'd11, 1'b0);
        driveWord(32'h000000FF, 32'h00000000, 10'd12, 1'b0, 0);
        driveWord(32'h000000FF, 32'h00000000, 10'd12, 1'b0, 1);
        @(negedge Clk);
        InValid = 1'b0;
        #2 Reset = 1'b0;
        #1;
        check("midreset_inready", InReady, 0);
        check("midreset_sadvalid", SadValid, 0);
        check("midreset_done", Done, 0);
        check("midreset_sadout", SadOut, 0);
        check("midreset_sadidx", SadIdx, 0);
        check("midreset_minsad", MinSad, ALL_ONES);
        check("midreset_minidx", MinIdx, 0);
        @(negedge Clk);
        Reset = 1'b1;

        // Recovery after reset.
        pushDone(12'd4, 10'd2);
        doStart();
        sendBlock({4{32'h00000001}}, {4{32'h00000002}}, 10'd2, 1'b1, 12'd4, 1'b0, 12'd4, 10'd2, 1'b0);

        n = 0;
        while ((sbQ.size() != 0 || doneQ.size() != 0 || pendMin) && n < 50) begin
            @(negedge Clk);
            n++;
        end
        repeat (2) @(negedge Clk);
        check("sadvalid_pending", sbQ.size(), 0);
        check("done_pending", doneQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
